// File: rtl/branch_wb_arbiter_pkg.sv
// Shared types for the branch-writeback path: ROB index split, writeback payload,
// age compare helper and perf counter width.
package branch_wb_arbiter_pkg;

  localparam int ROBIDX_W   = 6;
  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2,
    BR_RET  = 2'd3
  } BranchType;

  // MSB flips each time the ROB pointer wraps; the rest is the entry index.
  typedef struct packed {
    logic                flip;
    logic [ROBIDX_W-2:0] idx;
  } robIdx_t;

  typedef struct packed {
    robIdx_t   rob_idx;
    BranchType br_type;
    logic      taken;
    logic      has_mispred;
    logic [31:0] target_pc;
  } branchwbInfo_t;

  // Same flip: smaller index is older. Different flip: the larger index was
  // allocated before the wrap and is therefore the older one.
  function automatic logic rob_is_older(input robIdx_t a, input robIdx_t b);
    if (a.flip == b.flip) begin
      return a.idx < b.idx;
    end else begin
      return a.idx > b.idx;
    end
  endfunction

endpackage

// File: rtl/branch_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req from ptr upward with wrap, grants the first
// requester, and moves ptr past the winner when the caller reports a transfer.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant
);

  localparam logic [IDX_W:0]   N_L  = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W:0]   cand;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_q} + off[IDX_W:0];
      if (cand >= N_L) begin
        cand = cand - N_L;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        grant[cand[IDX_W-1:0]] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

  // With a single requester LAST is 0, so the pointer can never leave 0.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/branch_wb_arbiter.sv
// Merges NUM_BRU branch writebacks onto the single registered FTQ port and tracks
// the oldest mispredict since the last squash. Optional perf counters: BRANCH_WB_ARB_PERF_EN.
module branch_wb_arbiter
  import branch_wb_arbiter_pkg::*;
#(
  parameter int NUM_BRU = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_squash_vld,
  input  logic [NUM_BRU-1:0]           i_wb_vld,
  output logic [NUM_BRU-1:0]           o_wb_rdy,
  input  branchwbInfo_t [NUM_BRU-1:0]  i_wb_info,
  output logic                         o_ftq_vld,
  input  logic                         i_ftq_rdy,
  output branchwbInfo_t                o_ftq_info,
  output logic                         o_mispred_vld,
  output branchwbInfo_t                o_mispred_info
`ifdef BRANCH_WB_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]        o_perf_mispred_cnt,
  output logic [PERF_CNT_W-1:0]        o_perf_stall_cnt
`endif
);

  localparam int IDX_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

  logic [NUM_BRU-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               free;
  logic               can_accept;
  logic               hs;
  branchwbInfo_t      sel_info;

  logic               ftq_vld_q, ftq_vld_d;
  branchwbInfo_t      ftq_info_q, ftq_info_d;
  logic               mis_vld_q, mis_vld_d;
  branchwbInfo_t      mis_info_q, mis_info_d;

  rr_arbiter #(
    .N (NUM_BRU)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (i_wb_vld),
    .advance   (hs),
    .grant_idx (grant_idx),
    .grant     (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NUM_BRU; k++) begin
      if (grant[k]) begin
        grant_idx = k[IDX_W-1:0];
      end
    end
  end

  // Gating with rst keeps every ready low while reset is held.
  assign free       = !ftq_vld_q || i_ftq_rdy;
  assign can_accept = free && !i_squash_vld && !rst;

  for (genvar gi = 0; gi < NUM_BRU; gi++) begin : g_rdy
    assign o_wb_rdy[gi] = grant[gi] && can_accept;
  end

  assign hs       = |(i_wb_vld & o_wb_rdy);
  assign sel_info = i_wb_info[grant_idx];

  always_comb begin
    ftq_vld_d  = ftq_vld_q;
    ftq_info_d = ftq_info_q;
    if (i_squash_vld) begin
      ftq_vld_d = 1'b0;
    end else if (hs) begin
      ftq_vld_d  = 1'b1;
      ftq_info_d = sel_info;
    end else if (i_ftq_rdy) begin
      ftq_vld_d = 1'b0;
    end
  end

  // A same-age collision is illegal; rob_is_older returns 0 so the held entry wins.
  always_comb begin
    mis_vld_d  = mis_vld_q;
    mis_info_d = mis_info_q;
    if (i_squash_vld) begin
      mis_vld_d = 1'b0;
    end else if (hs && sel_info.has_mispred &&
                 (!mis_vld_q || rob_is_older(sel_info.rob_idx, mis_info_q.rob_idx))) begin
      mis_vld_d  = 1'b1;
      mis_info_d = sel_info;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftq_vld_q  <= 1'b0;
      ftq_info_q <= '0;
      mis_vld_q  <= 1'b0;
      mis_info_q <= '0;
    end else begin
      ftq_vld_q  <= ftq_vld_d;
      ftq_info_q <= ftq_info_d;
      mis_vld_q  <= mis_vld_d;
      mis_info_q <= mis_info_d;
    end
  end

  assign o_ftq_vld      = ftq_vld_q;
  assign o_ftq_info     = ftq_info_q;
  assign o_mispred_vld  = mis_vld_q;
  assign o_mispred_info = mis_info_q;

`ifdef BRANCH_WB_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] perf_mis_q, perf_mis_d;
  logic [PERF_CNT_W-1:0] perf_stall_q, perf_stall_d;

  // Squash does not clear these; a squash cycle with pending requests counts as a stall.
  always_comb begin
    perf_mis_d   = perf_mis_q;
    perf_stall_d = perf_stall_q;
    if (hs && sel_info.has_mispred) begin
      perf_mis_d = perf_mis_q + 1'b1;
    end
    if ((|i_wb_vld) && !hs) begin
      perf_stall_d = perf_stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_mis_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_mis_q   <= perf_mis_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign o_perf_mispred_cnt = perf_mis_q;
  assign o_perf_stall_cnt   = perf_stall_q;
`endif

endmodule
